// File: rtl/spi_peripheral_pkg.sv
// Shared constants and helpers for the SPI peripheral (mode 0, MSB first, 8-bit frames).
package spi_peripheral_pkg;

  localparam int unsigned SPI_BITS = 8;
  localparam int unsigned CNT_W    = $clog2(SPI_BITS);

  localparam logic [0:0] STATE_IDLE   = 1'b0;
  localparam logic [0:0] STATE_ACTIVE = 1'b1;

  localparam logic [SPI_BITS-1:0] FILL_BYTE_DEFAULT = 8'h00;

  typedef logic [SPI_BITS-1:0] spi_byte_t;

  // Byte presented to the shifter at frame/byte start.
  function automatic spi_byte_t tx_source(input logic full, input spi_byte_t hold,
                                          input spi_byte_t fill);
    return full ? hold : fill;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Pin synchroniser with history flop; provides synchronised level and rise/fall strobes.
module spi_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~hist_q;
  assign fall_o  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_peripheral.sv
// SPI mode-0 responder with byte-level TX holding / RX valid-ack handshakes toward the CPU.
// Optional build macro SPI_PERIPHERAL_OVERRUN_EN: keep first unacked byte and flag overrun.
module spi_peripheral
  import spi_peripheral_pkg::*;
#(
  parameter int unsigned         SYNC_STAGES = 2,
  parameter logic [SPI_BITS-1:0] FILL_BYTE   = FILL_BYTE_DEFAULT
) (
  input  logic                raw_clk,
  input  logic                reset_n,
  input  logic                cs_n,
  input  logic                sclk,
  input  logic                mosi,
  output logic                miso,
  input  logic [SPI_BITS-1:0] data_tx,
  input  logic                tx_load,
  output logic                tx_ready,
  output logic [SPI_BITS-1:0] data_rx,
  output logic                rx_valid,
  input  logic                rx_ack,
  output logic                busy,
  output logic                overrun
);

  logic cs_s, cs_rise, cs_fall;
  logic sclk_s_unused, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(raw_clk), .rst_n(reset_n), .pin_i(cs_n),
    .level_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(raw_clk), .rst_n(reset_n), .pin_i(sclk),
    .level_o(sclk_s_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(raw_clk), .rst_n(reset_n), .pin_i(mosi),
    .level_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  spi_byte_t        tx_shift_q, tx_shift_d;
  spi_byte_t        rx_shift_q, rx_shift_d;
  spi_byte_t        hold_q, hold_d;
  logic             hold_empty_q, hold_empty_d;
  logic             reload_q, reload_d;
  spi_byte_t        data_rx_q, data_rx_d;
  logic             rx_valid_q, rx_valid_d;
  logic             overrun_q, overrun_d;
  logic             miso_q, miso_d;
  logic             busy_q, busy_d;
  logic             consume;
  logic             complete;
  spi_byte_t        rx_byte;

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= STATE_IDLE;
      count_q      <= '0;
      tx_shift_q   <= FILL_BYTE;
      rx_shift_q   <= '0;
      hold_q       <= '0;
      hold_empty_q <= 1'b1;
      reload_q     <= 1'b0;
      data_rx_q    <= '0;
      rx_valid_q   <= 1'b0;
      overrun_q    <= 1'b0;
      miso_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      hold_q       <= hold_d;
      hold_empty_q <= hold_empty_d;
      reload_q     <= reload_d;
      data_rx_q    <= data_rx_d;
      rx_valid_q   <= rx_valid_d;
      overrun_q    <= overrun_d;
      miso_q       <= miso_d;
      busy_q       <= busy_d;
    end
  end

  // Frame sequencing; a cs edge always takes priority over an sclk edge.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    reload_d   = reload_q;
    consume    = 1'b0;
    complete   = 1'b0;
    rx_byte    = {rx_shift_q[SPI_BITS-2:0], mosi_s};

    case (state_q)
      STATE_IDLE: begin
        if (cs_fall) begin
          state_d    = STATE_ACTIVE;
          count_d    = '0;
          reload_d   = 1'b0;
          tx_shift_d = tx_source(~hold_empty_q, hold_q, FILL_BYTE);
          consume    = ~hold_empty_q;
        end
      end
      STATE_ACTIVE: begin
        if (cs_rise) begin
          state_d    = STATE_IDLE;
          count_d    = '0;
          reload_d   = 1'b0;
          rx_shift_d = '0;
          tx_shift_d = FILL_BYTE;
        end else if (sclk_rise) begin
          rx_shift_d = rx_byte;
          if (count_q == CNT_W'(SPI_BITS - 1)) begin
            complete = 1'b1;
            count_d  = '0;
            reload_d = 1'b1;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end else if (sclk_fall) begin
          if (reload_q) begin
            tx_shift_d = tx_source(~hold_empty_q, hold_q, FILL_BYTE);
            consume    = ~hold_empty_q;
            reload_d   = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[SPI_BITS-2:0], 1'b0};
          end
        end
      end
      default: state_d = STATE_IDLE;
    endcase

    miso_d = (state_d == STATE_ACTIVE) ? tx_shift_d[SPI_BITS-1] : 1'b0;
    busy_d = ~cs_s;
  end

  // TX holding register: a load is also accepted in the cycle the held byte is consumed.
  always_comb begin
    hold_d       = hold_q;
    hold_empty_d = hold_empty_q;
    if (consume) hold_empty_d = 1'b1;
    if (tx_load && (hold_empty_q || consume)) begin
      hold_d       = data_tx;
      hold_empty_d = 1'b0;
    end
  end

  // RX handshake; a completing byte beats a simultaneous ack.
  always_comb begin
    data_rx_d  = data_rx_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    overrun_d = overrun_q;
    if (complete) begin
      if (rx_valid_q) begin
        overrun_d = 1'b1;
      end else begin
        data_rx_d  = rx_byte;
        rx_valid_d = 1'b1;
      end
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
      overrun_d  = 1'b0;
    end
`else
    if (complete) begin
      data_rx_d  = rx_byte;
      rx_valid_d = 1'b1;
    end else if (rx_ack) begin
      rx_valid_d = 1'b0;
    end
`endif
  end

  assign miso     = miso_q;
  assign tx_ready = hold_empty_q;
  assign data_rx  = data_rx_q;
  assign rx_valid = rx_valid_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed self-checking bench for spi_peripheral acting as an SPI mode-0 host.
module tb_spi_peripheral;

  logic       raw_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cs_n    = 1'b1;
  logic       sclk    = 1'b0;
  logic       mosi    = 1'b0;
  logic       miso;
  logic [7:0] data_tx = 8'h00;
  logic       tx_load = 1'b0;
  logic       tx_ready;
  logic [7:0] data_rx;
  logic       rx_valid;
  logic       rx_ack  = 1'b0;
  logic       busy;
  logic       overrun;

  int n_cmp = 0;
  int n_mis = 0;

  spi_peripheral dut (
    .raw_clk(raw_clk), .reset_n(reset_n), .cs_n(cs_n), .sclk(sclk), .mosi(mosi),
    .miso(miso), .data_tx(data_tx), .tx_load(tx_load), .tx_ready(tx_ready),
    .data_rx(data_rx), .rx_valid(rx_valid), .rx_ack(rx_ack), .busy(busy),
    .overrun(overrun)
  );

  always #5 raw_clk = ~raw_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge raw_clk);
  endtask

  task automatic load_tx(input logic [7:0] b);
    @(negedge raw_clk);
    data_tx = b;
    tx_load = 1'b1;
    @(negedge raw_clk);
    tx_load = 1'b0;
  endtask

  task automatic ack_rx();
    @(negedge raw_clk);
    rx_ack = 1'b1;
    @(negedge raw_clk);
    rx_ack = 1'b0;
    wait_clks(2);
  endtask

  task automatic start_frame();
    cs_n = 1'b0;
    wait_clks(8);
  endtask

  task automatic end_frame();
    cs_n = 1'b1;
    wait_clks(8);
  endtask

  // Shift n bits MSB first; sample miso just before each rising sclk edge.
  task automatic spi_bits(input logic [7:0] mo, input int n, input logic do_load,
                          input logic [7:0] ld, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = mo[i];
      wait_clks(6);
      mi[i] = miso;
      if (do_load && i == 4) load_tx(ld);
      sclk = 1'b1;
      wait_clks(6);
      sclk = 1'b0;
    end
    wait_clks(6);
  endtask

  task automatic spi_byte(input logic [7:0] mo, output logic [7:0] mi);
    spi_bits(mo, 8, 1'b0, 8'h00, mi);
  endtask

  logic [7:0] mi;

  initial begin
    wait_clks(3);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_data_rx", data_rx, 8'h00);
    check("rst_miso", miso, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    reset_n = 1'b1;
    wait_clks(4);

    // Queued A5, host sends 3C
    load_tx(8'hA5);
    check("a5_tx_ready_full", tx_ready, 0);
    start_frame();
    check("a5_busy", busy, 1);
    check("a5_tx_ready_free", tx_ready, 1);
    spi_byte(8'h3C, mi);
    check("a5_miso", mi, 8'hA5);
    end_frame();
    check("a5_data_rx", data_rx, 8'h3C);
    check("a5_rx_valid", rx_valid, 1);
    check("a5_busy_off", busy, 0);
    check("a5_miso_idle", miso, 0);
    ack_rx();
    check("a5_ack", rx_valid, 0);

    // Empty holding register shifts fill byte
    start_frame();
    spi_byte(8'h5A, mi);
    end_frame();
    check("fill_miso", mi, 8'h00);
    check("fill_data_rx", data_rx, 8'h5A);
    ack_rx();

    // Two-byte frame, second byte loaded mid-byte
    load_tx(8'h11);
    start_frame();
    spi_bits(8'hAA, 8, 1'b1, 8'h22, mi);
    check("two_miso0", mi, 8'h11);
    check("two_rx0", data_rx, 8'hAA);
    check("two_ready0", tx_ready, 1);
    spi_byte(8'h55, mi);
    check("two_miso1", mi, 8'h22);
    check("two_rx1", data_rx, 8'h55);
    end_frame();
    ack_rx();

    // Partial frame discarded, next frame clean
    start_frame();
    spi_bits(8'hFF, 5, 1'b0, 8'h00, mi);
    end_frame();
    check("part_rx_valid", rx_valid, 0);
    check("part_busy", busy, 0);
    check("part_miso", miso, 0);
    start_frame();
    spi_byte(8'hF0, mi);
    end_frame();
    check("part_next_rx", data_rx, 8'hF0);
    check("part_next_valid", rx_valid, 1);
    ack_rx();

    // Two frames with no ack in between
    start_frame();
    spi_byte(8'h01, mi);
    end_frame();
    start_frame();
    spi_byte(8'h02, mi);
    end_frame();
    check("ovr_valid", rx_valid, 1);
`ifdef SPI_PERIPHERAL_OVERRUN_EN
    check("ovr_data_rx", data_rx, 8'h01);
    check("ovr_flag", overrun, 1);
    ack_rx();
    check("ovr_ack_valid", rx_valid, 0);
    check("ovr_ack_flag", overrun, 0);
`else
    check("ovr_data_rx", data_rx, 8'h02);
    check("ovr_flag", overrun, 0);
    ack_rx();
    check("ovr_ack_valid", rx_valid, 0);
`endif

    // Reset mid-byte with a byte queued and data_rx nonzero
    load_tx(8'h77);
    start_frame();
    spi_bits(8'hE7, 3, 1'b0, 8'h00, mi);
    @(negedge raw_clk);
    reset_n = 1'b0;
    #1;
    check("mrst_tx_ready", tx_ready, 1);
    check("mrst_rx_valid", rx_valid, 0);
    check("mrst_data_rx", data_rx, 8'h00);
    check("mrst_miso", miso, 0);
    check("mrst_busy", busy, 0);
    check("mrst_overrun", overrun, 0);
    cs_n = 1'b1;
    wait_clks(3);
    reset_n = 1'b1;
    wait_clks(6);
    start_frame();
    spi_byte(8'hC3, mi);
    end_frame();
    check("mrst_frame_rx", data_rx, 8'hC3);
    check("mrst_frame_valid", rx_valid, 1);
    check("mrst_frame_miso", mi, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
- SPI responder (mode 0, CPOL=0/CPHA=0, MSB first, 8-bit frames) for the existing SPI controller when the FPGA sits on the other end of a bus.
- Lets an external host read and write bytes to the soft processor's memory-mapped I/O.
- Asynchronous pin inputs are synchronised into raw_clk.
- Byte-level handshakes face the CPU bus: a TX holding register and an RX register with valid/ack.

Parameters:
SYNC_STAGES, 2, flip-flop depth of each pin synchroniser (minimum 2)
FILL_BYTE, 8'h00, byte shifted out on miso when no TX byte is queued at frame or byte start

Ports:
raw_clk  input  1  system clock; all state on posedge
reset_n  input  1  asynchronous, active-low reset
cs_n  input  1  chip select from pin, active low, asynchronous
sclk  input  1  serial clock from pin, asynchronous, at most raw_clk/8
mosi  input  1  serial data in from pin
miso  output  1  serial data out; tx_shift[7] while selected, 0 while deselected
data_tx  input  8  byte to queue for transmission
tx_load  input  1  write data_tx into the holding register
tx_ready  output  1  holding register empty
data_rx  output  8  last complete received byte
rx_valid  output  1  data_rx holds an unacknowledged byte
rx_ack  input  1  clears rx_valid
busy  output  1  synchronised cs_n is low
overrun  output  1  sticky overrun flag (feature only, else tied 0)

Behaviour:
- Reset values:
  - Synchronisers: cs=1, sclk=0, mosi=0.
  - state=STATE_IDLE, count=0, tx_shift=FILL_BYTE, holding empty.
  - tx_ready=1, rx_valid=0, data_rx=0, miso=0, busy=0, overrun=0.
- Synchronisation and edge detection:
  - Each pin passes through SYNC_STAGES flops plus one history flop.
  - Edges are taken from the last two stages.
  - Pin-to-action latency is SYNC_STAGES+1 raw_clk cycles.
- STATE_IDLE: on a cs falling edge:
  - Load tx_shift from the holding register if full (mark it empty, tx_ready=1), else from FILL_BYTE.
  - Set count=0 and go to STATE_ACTIVE.
- STATE_ACTIVE:
  - sclk rising edge:
    - rx_shift <= {rx_shift[6:0], mosi_s} and count++.
    - When count==7: data_rx <= {rx_shift[6:0], mosi_s}, rx_valid<=1, count wraps to 0, reload_pending<=1.
  - sclk falling edge:
    - If reload_pending: load tx_shift from holding or FILL_BYTE, clear reload_pending.
    - Else tx_shift <= tx_shift<<1.
  - cs rising edge (any count): return to STATE_IDLE, count=0, partial byte discarded, no rx_valid, miso=0. The holding register is preserved.
- Handshakes:
  - tx_load is accepted only while tx_ready=1; tx_load while tx_ready=0 is ignored.
  - Holding consumed and tx_load in the same cycle: the new byte enters holding and tx_ready stays 0.
  - rx_ack clears rx_valid next cycle.
  - Byte completion and rx_ack in the same cycle: set wins, rx_valid=1.
  - A byte completing while rx_valid=1 overwrites data_rx; rx_valid stays 1.
- Simultaneous sclk and cs edges in one cycle: the cs edge has priority.
- Back-to-back frames are allowed; each cs falling edge restarts at bit 7.

Optional Feature:
- Macro: SPI_PERIPHERAL_OVERRUN_EN.
- Defined:
  - A byte completing while rx_valid=1 does not overwrite data_rx; it is dropped and overrun is set.
  - overrun clears only when rx_ack is high and no byte completes in that cycle.
- Undefined: overwrite behaviour as above; overrun is tied 0.

Decomposition:
- Shared package/include: STATE_IDLE=0, STATE_ACTIVE=1, SPI_BITS=8, default FILL_BYTE.
- One sub-module, spi_sync: an SYNC_STAGES synchroniser plus history flop, outputting the synchronised level, rise and fall. Instantiated for cs_n, sclk and mosi (mosi uses the level only).

Test Plan:
- tx_load data_tx=8'hA5, then host frame sending 8'h3C: miso bits read 1,0,1,0,0,1,0,1; data_rx=8'h3C; rx_valid=1; tx_ready returns to 1 at the cs falling edge.
- Empty holding register, one-byte frame: miso shifts FILL_BYTE 8'h00.
- Two-byte frame with 8'h11 queued, then 8'h22 loaded mid-byte-1: miso yields 8'h11 then 8'h22; data_rx updates twice.
- cs_n deasserted after 5 sclk rising edges: rx_valid stays 0, busy falls; the next full frame of 8'hF0 yields data_rx=8'hF0.
- Two frames 8'h01 then 8'h02 with no rx_ack:
  - Without the macro: data_rx=8'h02, overrun=0.
  - With SPI_PERIPHERAL_OVERRUN_EN: data_rx=8'h01, overrun=1; rx_ack then clears both flags.
- reset_n pulsed low mid-byte: all outputs return to reset values immediately; the following frame receives correctly from bit 7.
